// File: rtl/mult_pkg.sv
// Shared types and sizing for the two-requester multiplier scheduler.
package mult_pkg;

    localparam int OP_W               = 8;
    localparam int PROD_W             = 16;
    localparam int NUM_REQ            = 2;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arbiter2
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               reset_a,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic               winner
);

    logic rr_last_r;

    // Winner selection from current requests and last winner
    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~rr_last_r;
            default: winner = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = owner_onehot(winner);
        end else begin
            grant = 2'b00;
        end
    end

    // Last-winner history; reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            rr_last_r <= 1'b1;
        end else if (update) begin
            rr_last_r <= winner;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential 8x8 multiplier between two requesters with round-robin grant.
// Optional abort of a stuck operation: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_pkg::*;
`ifdef MULT_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic               clk,
    input  logic               reset_a,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [OP_W-1:0]    req_a0,
    input  logic [OP_W-1:0]    req_b0,
    input  logic [OP_W-1:0]    req_a1,
    input  logic [OP_W-1:0]    req_b1,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [PROD_W-1:0]  rsp_product,
    output logic               rsp_err,
    output logic [OP_W-1:0]    mult_dataa,
    output logic [OP_W-1:0]    mult_datab,
    output logic               mult_start,
    input  logic               mult_done,
    input  logic [PROD_W-1:0]  mult_product,
    output logic               busy
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 owner_r;
    logic                 first_r;
    logic [OP_W-1:0]      dataa_r;
    logic [OP_W-1:0]      datab_r;
    logic [PROD_W-1:0]    product_r;
    logic                 start_r;
    logic                 busy_r;
    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic                 accept_s;
    logic                 capture_s;
    logic                 timeout_s;
    logic                 timeout_hit_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic                 winner_s;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_a (reset_a),
        .req     (req_valid),
        .update  (accept_s),
        .grant   (grant_s),
        .winner  (winner_s)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // RUN-cycle counter, zero outside RUN
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Error flag: set by an abort, cleared by a real result
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            err_r <= 1'b0;
        end else if (capture_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err       = err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    // Next-state decode; done in the first RUN cycle may be stale and is ignored
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (mult_done && !first_r) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else if (timeout_hit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RESP: begin
                if (rsp_ready[owner_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Acceptance is only offered in IDLE, and only to the granted requester
    always_comb begin
        req_ready = 2'b00;
        if (state_r == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // State, ownership and registered control outputs
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            first_r     <= 1'b0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 2'b00;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= accept_s ? winner_s : owner_r;
            first_r     <= accept_s;
            start_r     <= (state_nxt_s == RUN);
            busy_r      <= (state_nxt_s != IDLE);
            rsp_valid_r <= (state_nxt_s == RESP) ? owner_onehot(owner_r) : 2'b00;
        end
    end

    // Operand latch at grant; held for the whole operation
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            dataa_r <= {OP_W{1'b0}};
            datab_r <= {OP_W{1'b0}};
        end else if (accept_s) begin
            dataa_r <= winner_s ? req_a1 : req_a0;
            datab_r <= winner_s ? req_b1 : req_b0;
        end else begin
            dataa_r <= dataa_r;
            datab_r <= datab_r;
        end
    end

    // Result register; an aborted operation returns zero
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            product_r <= {PROD_W{1'b0}};
        end else if (capture_s) begin
            product_r <= mult_product;
        end else if (timeout_s) begin
            product_r <= {PROD_W{1'b0}};
        end else begin
            product_r <= product_r;
        end
    end

    assign mult_dataa  = dataa_r;
    assign mult_datab  = datab_r;
    assign mult_start  = start_r;
    assign busy        = busy_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_product = product_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier and scheduling model.
module tb_mult_arbiter;

    logic        clk;
    logic        reset_a;
    logic [1:0]  req_valid;
    logic [7:0]  req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic [7:0]  mult_dataa, mult_datab;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural multiplier: done once start has been high for lat_cur cycles
    logic        man_mode = 1'b0;
    logic        man_done = 1'b0;
    logic [15:0] man_prod = 16'h0000;
    int          lat_cur  = 1;
    int          mcnt     = 0;
    logic        auto_done;

    // Scheduling model state
    logic [1:0] pend;
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    int         last_m;

    mult_arbiter dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .req_valid    (req_valid),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mult_start) mcnt <= 0;
        else             mcnt <= mcnt + 1;
    end

    assign auto_done    = mult_start && (mcnt >= lat_cur);
    assign mult_done    = man_mode ? man_done : auto_done;
    assign mult_product = man_mode ? man_prod :
                          (auto_done ? ({8'h00, mult_dataa} * {8'h00, mult_datab}) : 16'hDEAD);

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        req_a0 = pa[0]; req_b0 = pb[0];
        req_a1 = pa[1]; req_b1 = pb[1];
    endtask

    // One full transaction; new requests are added to the pending set first
    task automatic run_txn(input logic [1:0] newv, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int lat, input int hold, input bit nonown);
        int w;
        int runc;
        int expprod;
        logic [15:0] held;
        if (newv[0]) begin pend[0] = 1'b1; pa[0] = a0; pb[0] = b0; end
        if (newv[1]) begin pend[1] = 1'b1; pa[1] = a1; pb[1] = b1; end
        drive_reqs();
        lat_cur = lat;
        rsp_ready = 2'b00;
        w = (pend == 2'b11) ? ((last_m == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        expprod = int'(pa[w]) * int'(pb[w]);
        @(negedge clk);
        chk("req_ready_grant", req_ready, oh(w));
        chk("busy_idle", busy, 1'b0);
        @(posedge clk); #1;
        pend[w] = 1'b0;
        last_m  = w;
        drive_reqs();
        runc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) break;
            if (mult_start) runc++;
            chk("req_ready_run", req_ready, 2'b00);
            chk("dataa_hold", mult_dataa, pa[w]);
            chk("datab_hold", mult_datab, pb[w]);
            @(posedge clk); #1;
        end
        chk("rsp_valid", rsp_valid, oh(w));
        chk("rsp_product", rsp_product, expprod[15:0]);
        chk("rsp_err", rsp_err, 1'b0);
        chk("run_cycles", runc, (lat < 1) ? 2 : lat + 1);
        chk("start_resp", mult_start, 1'b0);
        held = rsp_product;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = nonown ? oh(1 - w) : 2'b00;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid, oh(w));
            chk("hold_product", rsp_product, held);
            chk("hold_start", mult_start, 1'b0);
            chk("hold_no_accept", req_ready, 2'b00);
        end
        rsp_ready = oh(w);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        chk("idle_rsp_valid", rsp_valid, 2'b00);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        pend = 2'b00; last_m = 1;
        pa[0] = 8'h00; pb[0] = 8'h00; pa[1] = 8'h00; pb[1] = 8'h00;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = 8'h00; req_b0 = 8'h00; req_a1 = 8'h00; req_b1 = 8'h00;
        reset_a = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_start", mult_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_dataa", mult_dataa, 8'h00);
        chk("rst_datab", mult_datab, 8'h00);
        chk("rst_product", rsp_product, 16'h0000);
        @(negedge clk); reset_a = 1'b1;
        @(posedge clk); #1;

        // Single request: start high 4 cycles, 0x0F*0x0A
        run_txn(2'b01, 8'h0F, 8'h0A, 8'h00, 8'h00, 3, 0, 1'b0);

        // Reset while running: outputs clear immediately, requester 0 wins next tie
        pend = 2'b01; pa[0] = 8'h33; pb[0] = 8'h44; drive_reqs();
        man_mode = 1'b1; man_done = 1'b0;
        @(posedge clk); #1;
        pend = 2'b00; drive_reqs();
        @(posedge clk); #2;
        reset_a = 1'b0;
        #1;
        chk("rrun_start", mult_start, 1'b0);
        chk("rrun_busy", busy, 1'b0);
        chk("rrun_dataa", mult_dataa, 8'h00);
        chk("rrun_rsp_valid", rsp_valid, 2'b00);
        @(negedge clk); reset_a = 1'b1; man_mode = 1'b0;
        last_m = 1;
        @(posedge clk); #1;

        // Contention: 0 first, then 1 beats a fresh request from 0, then 0 drains
        run_txn(2'b11, 8'hFF, 8'hFF, 8'h12, 8'h34, 2, 0, 1'b0);
        run_txn(2'b01, 8'h05, 8'h07, 8'h00, 8'h00, 1, 0, 1'b0);
        run_txn(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 4, 0, 1'b0);

        // Response backpressure with the other requester waiting
        run_txn(2'b11, 8'hA5, 8'h3C, 8'h81, 8'h7E, 2, 5, 1'b1);
        run_txn(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1'b0);

        // Stale done held into the first RUN cycle must not be taken
        pend = 2'b01; pa[0] = 8'h21; pb[0] = 8'h09; drive_reqs();
        man_mode = 1'b1; man_done = 1'b1; man_prod = 16'h1111;
        @(negedge clk);
        chk("stale_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        pend = 2'b00; drive_reqs();
        @(negedge clk);
        chk("stale_start", mult_start, 1'b1);
        @(posedge clk); #1;
        man_done = 1'b0;
        @(negedge clk);
        chk("stale_not_taken", rsp_valid, 2'b00);
        @(posedge clk); #1;
        man_done = 1'b1; man_prod = 16'h0129;
        @(negedge clk);
        chk("stale_wait", rsp_valid, 2'b00);
        @(posedge clk); #1;
        man_done = 1'b0; man_prod = 16'h2222;
        @(negedge clk);
        chk("stale_rsp_valid", rsp_valid, 2'b01);
        chk("stale_product", rsp_product, 16'h0129);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00; man_mode = 1'b0;
        last_m = 0;

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            logic [1:0] nv;
            nv = 2'($urandom_range(0, 3)) & ~pend;
            if ((pend | nv) == 2'b00) nv = oh(int'($urandom_range(0, 1)));
            run_txn(nv, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'($urandom));
        end
        while (pend != 2'b00) run_txn(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, 1'b0);

        // Done never arrives
        pend = 2'b01; pa[0] = 8'h77; pb[0] = 8'h66; drive_reqs();
        man_mode = 1'b1; man_done = 1'b0; man_prod = 16'h5555;
        @(posedge clk); #1;
        pend = 2'b00; drive_reqs();
`ifdef MULT_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("tmo_running", rsp_valid, 2'b00);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_rsp_valid", rsp_valid, 2'b01);
        chk("tmo_err", rsp_err, 1'b1);
        chk("tmo_product", rsp_product, 16'h0000);
`else
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("notmo_busy", busy, 1'b1);
        chk("notmo_start", mult_start, 1'b1);
        chk("notmo_rsp_valid", rsp_valid, 2'b00);
        chk("notmo_err", rsp_err, 1'b0);
`endif
        reset_a = 1'b0;
        #1;
        chk("final_rst_busy", busy, 1'b0);
        @(negedge clk); reset_a = 1'b1; man_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
